// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared pipeline-stage types (stage occupancy state).
// Revision : 1.0
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_latch.sv
`default_nettype none
// ============================================================================
// pipe_skid_latch : two-entry (head + skid) pipeline stage with flush and ack.
// Revision : 1.0
// ============================================================================
module pipe_skid_latch
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 128,
  parameter logic [DATA_W-1:0]  CLR_MASK = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              ack,
  output logic [1:0]        occupancy
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_head;
  logic [DATA_W-1:0]   r_skid;

  state_t              w_state_nx;
  logic [DATA_W-1:0]   w_head_nx;
  logic [DATA_W-1:0]   w_skid_nx;
  logic                w_push;
  logic                w_pop;

  // Handshake outputs come straight from the state register so that
  // in_ready never depends combinationally on flush or downstream ready.
  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_head;
  assign occupancy = occ_of(r_state);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_state_nx = r_state;
    w_head_nx  = r_head;
    w_skid_nx  = r_skid;
    if (flush) begin
      w_state_nx = EMPTY;
      w_head_nx  = '0;
      w_skid_nx  = '0;
    end else begin
      // Ack only scrubs a head that stays put; a popping head leaves anyway.
      if (ack && out_valid && !w_pop)
        w_head_nx = r_head & ~CLR_MASK;
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nx = ONE;
            w_head_nx  = in_data;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_head_nx = in_data;
          end else if (w_push) begin
            w_state_nx = TWO;
            w_skid_nx  = in_data;
          end else if (w_pop) begin
            w_state_nx = EMPTY;
            w_head_nx  = '0;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_state_nx = ONE;
            w_head_nx  = r_skid;
            w_skid_nx  = '0;
          end
        end
        default: begin
          w_state_nx = EMPTY;
          w_head_nx  = '0;
          w_skid_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_head  <= w_head_nx;
      r_skid  <= w_skid_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_latch.sv
`default_nettype none
// ============================================================================
// tb_pipe_skid_latch : randomized bench against a queue-based stage model.
// Revision : 1.0
// ============================================================================
module tb_pipe_skid_latch;

  localparam int          DW   = 32;
  localparam logic [31:0] MASK = 32'h3;

  logic          CLK;
  logic          nRST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic          ack;
  logic [1:0]    occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mq[$];

  pipe_skid_latch #(.DATA_W(DW), .CLR_MASK(MASK)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .ack(ack), .occupancy(occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] exp_data();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  // One clock of stimulus; the model applies the stage's rules as plain
  // queue operations on the same edge.
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic a);
    bit psh, pp;
    @(negedge CLK);
    in_valid = v; in_data = d; out_ready = r; flush = f; ack = a;
    @(posedge CLK);
    if (f) begin
      mq.delete();
    end else begin
      psh = v && (mq.size() < 2);
      pp  = r && (mq.size() > 0);
      if (a && mq.size() > 0 && !pp) mq[0] = mq[0] & ~MASK;
      if (pp) void'(mq.pop_front());
      if (psh) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; in_valid = 0; in_data = '0; out_ready = 0; flush = 0; ack = 0;
    mq.delete();
    repeat (2) @(posedge CLK);
    #1;
    n_tests++;
    if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset: got v=%0b rdy=%0b occ=%0d d=%h, want v=0 rdy=1 occ=0 d=0",
               out_valid, in_ready, occupancy, out_data);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_single();
    tick(1, 32'hA5A5A5A5, 1, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL single_out: got v=%0b d=%h, want v=1 d=a5a5a5a5", out_valid, out_data);
    end
    tick(0, '0, 1, 0, 0);
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL single_empty: got v=%0b occ=%0d d=%h, want v=0 occ=0 d=0",
               out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_backpressure();
    tick(1, 32'h1, 0, 0, 0);
    tick(1, 32'h2, 0, 0, 0);
    n_tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h1) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d rdy=%0b d=%h, want occ=2 rdy=0 d=1",
               occupancy, in_ready, out_data);
    end
    tick(1, 32'h3, 1, 0, 0);
    n_tests++;
    if (out_data !== 32'h2 || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_second: got d=%h occ=%0d, want d=2 occ=1", out_data, occupancy);
    end
    tick(0, '0, 1, 0, 0);
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%0b occ=%0d, want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    tick(1, 32'h11, 0, 0, 0);
    tick(1, 32'h22, 0, 0, 0);
    tick(1, 32'h33, 1, 1, 0);
    n_tests++;
    if (occupancy !== 2'd0 || out_data !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: got occ=%0d d=%h v=%0b rdy=%0b, want occ=0 d=0 v=0 rdy=1",
               occupancy, out_data, out_valid, in_ready);
    end
  endtask

  task automatic test_ack();
    tick(1, 32'hF, 0, 0, 0);
    tick(0, '0, 0, 0, 1);
    n_tests++;
    if (out_data !== 32'hC || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL ack_head: got d=%h occ=%0d, want d=c occ=1", out_data, occupancy);
    end
    // Ack on a two-entry stage must leave the skid entry intact.
    tick(1, 32'h7, 0, 0, 0);
    tick(0, '0, 0, 0, 1);
    tick(0, '0, 1, 0, 0);
    n_tests++;
    if (out_data !== 32'h7) begin
      n_fail++;
      $display("FAIL ack_skid: got d=%h, want d=7", out_data);
    end
    // Ack together with a pop is ignored for the popped head.
    tick(1, 32'hB, 1, 0, 1);
    n_tests++;
    if (out_data !== 32'hB) begin
      n_fail++;
      $display("FAIL ack_pop: got d=%h, want d=b", out_data);
    end
    tick(0, '0, 0, 1, 0);
    tick(0, '0, 0, 0, 1);
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL ack_empty: got v=%0b occ=%0d d=%h, want v=0 occ=0 d=0",
               out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_throughput();
    logic [DW-1:0] d;
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      tick(1, d, 1, 0, 0);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== d || occupancy !== 2'd1) begin
        n_fail++;
        $display("FAIL throughput[%0d]: got v=%0b d=%h occ=%0d, want v=1 d=%h occ=1",
                 i, out_valid, out_data, occupancy, d);
      end
    end
    tick(0, '0, 1, 0, 0);
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL throughput_drain: got v=%0b occ=%0d, want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_random();
    logic          v, r, f, a;
    logic [DW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 2) != 0);
      f = 1'($urandom_range(0, 15) == 0);
      a = 1'($urandom_range(0, 3) == 0);
      d = $urandom;
      tick(v, d, r, f, a);
      n_tests++;
      if ({out_valid, in_ready, occupancy, out_data} !==
          {mq.size() > 0, mq.size() < 2, 2'(mq.size()), exp_data()}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b rdy=%0b occ=%0d d=%h, want v=%0b rdy=%0b occ=%0d d=%h",
                 i, out_valid, in_ready, occupancy, out_data,
                 mq.size() > 0, mq.size() < 2, mq.size(), exp_data());
      end
    end
  endtask

  task automatic test_reset_midop();
    tick(1, 32'h55, 0, 0, 0);
    tick(1, 32'h66, 0, 0, 0);
    #1;
    nRST = 1'b0;
    mq.delete();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midop: got v=%0b rdy=%0b occ=%0d d=%h, want v=0 rdy=1 occ=0 d=0",
               out_valid, in_ready, occupancy, out_data);
    end
    nRST = 1'b1;
    tick(1, 32'h77, 0, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h77) begin
      n_fail++;
      $display("FAIL reset_first_push: got v=%0b d=%h, want v=1 d=77", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_ack();
    test_throughput();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 SHALL have parameter DATA_W, default 128: payload width in bits, legal range 1 to 1024.
REQ-002 SHALL have parameter CLR_MASK [DATA_W-1:0], default '0: payload bits cleared on ack.
REQ-003 SHALL have port CLK  input  1: clock, all state changes on rising edge.
REQ-004 SHALL have port nRST  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: upstream offers in_data.
REQ-006 SHALL have port in_ready  output  1: stage accepts upstream data this cycle.
REQ-007 SHALL have port in_data  input  DATA_W: upstream payload.
REQ-008 SHALL have port out_valid  output  1: out_data is valid.
REQ-009 SHALL have port out_ready  input  1: downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  DATA_W: head-entry payload.
REQ-011 SHALL have port flush  input  1: discard all held entries.
REQ-012 SHALL have port ack  input  1: memory-side completion; clears CLR_MASK bits of the head entry.
REQ-013 SHALL have port occupancy  output  2: held entry count, 0 to 2.

Function
REQ-014 SHALL hold two entries, head (H) and skid (S), in FIFO order, with state EMPTY, ONE or TWO.
REQ-015 SHALL define push as in_valid && in_ready, and pop as out_valid && out_ready.
REQ-016 SHALL drive in_ready = (state != TWO), decoded only from registered state.
REQ-017 SHALL drive out_valid = (state != EMPTY), out_data = H, and occupancy = 0/1/2 for EMPTY/ONE/TWO.
REQ-018 SHALL apply the EMPTY transitions: push -> ONE with H = in_data; otherwise stay EMPTY.
REQ-019 SHALL apply the ONE transitions:
- push and pop -> stay ONE, H = in_data.
- push only -> TWO, S = in_data.
- pop only -> EMPTY.
- neither -> hold.
REQ-020 SHALL apply the TWO transitions: pop -> ONE with H = S; otherwise hold. No push is possible in TWO.
REQ-021 SHALL give a latency of exactly 1 cycle: data pushed at edge N appears on out_data after edge N.
REQ-022 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-023 SHALL, on flush, take priority over every other input:
- next state EMPTY, H and S = 0.
- same-cycle push and pop are discarded.
- in_ready is not altered combinationally.
REQ-024 SHALL, on ack with state != EMPTY, no pop and no flush, set H = H & ~CLR_MASK; S is unaffected.
REQ-025 SHALL ignore ack when state is EMPTY or when H pops in the same cycle.
REQ-026 SHALL hold all storage and state unchanged when none of push, pop, flush or ack occurs (stall).
REQ-027 SHALL never reorder, duplicate or drop an accepted entry except by flush.
REQ-028 SHALL set entries vacated by pop to 0.

Reset
REQ-029 SHALL, while nRST = 0, force state EMPTY and H = S = 0, giving out_valid=0, out_data=0, occupancy=0, in_ready=1.
REQ-030 SHALL, on reset asserted mid-operation, discard all held entries immediately, independent of CLK.
REQ-031 SHALL accept a push on the first rising edge after nRST deasserts.

Structure
REQ-032 SHALL take state_t (EMPTY, ONE, TWO) from the shared package pipe_pkg.
REQ-033 SHALL use no sub-module; the stage is one module with a state/storage register block and one next-state combinational block.
REQ-034 SHALL be instantiable per pipeline stage, each payload packed as a struct cast to DATA_W.

Verification
REQ-035 SHALL cover single transfer: DATA_W=32, push 0xA5A5A5A5 with out_ready=1 -> out_valid=1 and out_data=0xA5A5A5A5 next cycle, then EMPTY.
REQ-036 SHALL cover backpressure: out_ready=0, push 0x1 then 0x2 -> occupancy=2, in_ready=0; out_ready=1 -> 0x1 then 0x2 on consecutive cycles.
REQ-037 SHALL cover flush: state TWO, flush with in_valid=1 and out_ready=1 -> occupancy=0, out_data=0, no entry emitted.
REQ-038 SHALL cover ack: CLR_MASK=0x3, H=0xF, out_ready=0, ack -> out_data=0xC next cycle; ack in EMPTY -> no change.
REQ-039 SHALL cover throughput: 100 random pushes with out_ready=1 -> 100 pops, in order, 1-cycle latency, occupancy never 2.
REQ-040 SHALL cover reset mid-operation: state TWO, nRST pulsed low between edges -> immediate out_valid=0, in_ready=1.
